// File: rtl/vga_scan_gen_if.sv
// Scan-generator bundle: raster coordinates and sync/colour out, renderer draw_pixel back in.
interface vga_scan_gen_if;
    logic       draw_pixel;
    logic [9:0] x;
    logic [8:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [7:0] rgb;
    logic       frame_start;

    modport master (
        input  draw_pixel,
        output x, y, hsync, vsync, video_on, rgb, frame_start
    );

    modport slave (
        output draw_pixel,
        input  x, y, hsync, vsync, video_on, rgb, frame_start
    );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan source: pixel-tick divider, h/v counters, one-tick registered sync/colour stage.
// Define SCAN_BORDER_EN to force FG_COLOR on the outermost visible rows/columns.
module vga_scan_gen #(
    parameter int          CLK_DIV   = 2,
    parameter int          H_VISIBLE = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33,
    parameter logic [7:0]  FG_COLOR  = 8'hFF,
    parameter logic [7:0]  BG_COLOR  = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    vga_scan_gen_if.master bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] divCnt;
    logic [9:0]       hCnt, vCnt;
    logic             tick, hEnd, vEnd, vis, hsRaw, vsRaw;
    logic [7:0]       pixColor;
    logic             hsyncQ, vsyncQ, videoOnQ, frameStartQ;
    logic [7:0]       rgbQ;

    assign tick  = (divCnt == DIV_W'(CLK_DIV - 1));
    assign hEnd  = (hCnt == 10'(H_TOTAL - 1));
    assign vEnd  = (vCnt == 10'(V_TOTAL - 1));
    assign vis   = (hCnt < 10'(H_VISIBLE)) && (vCnt < 10'(V_VISIBLE));
    assign hsRaw = !((hCnt >= 10'(HS_START)) && (hCnt < 10'(HS_END)));
    assign vsRaw = !((vCnt >= 10'(VS_START)) && (vCnt < 10'(VS_END)));

`ifdef SCAN_BORDER_EN
    logic onBorder;
    assign onBorder = (hCnt == 10'd0) || (hCnt == 10'(H_VISIBLE - 1)) ||
                      (vCnt == 10'd0) || (vCnt == 10'(V_VISIBLE - 1));
    assign pixColor = !vis ? 8'h00 : ((bus.draw_pixel || onBorder) ? FG_COLOR : BG_COLOR);
`else
    // Blanking must be black regardless of what the renderers report.
    assign pixColor = !vis ? 8'h00 : (bus.draw_pixel ? FG_COLOR : BG_COLOR);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt      <= '0;
            hCnt        <= '0;
            vCnt        <= '0;
            frameStartQ <= 1'b0;
        end else begin
            frameStartQ <= tick && hEnd && vEnd;
            if (tick) begin
                divCnt <= '0;
                if (hEnd) begin
                    hCnt <= '0;
                    vCnt <= vEnd ? 10'd0 : vCnt + 10'd1;
                end else begin
                    hCnt <= hCnt + 10'd1;
                end
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
        end
    end

    // Sync is registered alongside colour so both lag x/y by exactly one tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsyncQ   <= 1'b1;
            vsyncQ   <= 1'b1;
            videoOnQ <= 1'b0;
            rgbQ     <= 8'h00;
        end else if (tick) begin
            hsyncQ   <= hsRaw;
            vsyncQ   <= vsRaw;
            videoOnQ <= vis;
            rgbQ     <= pixColor;
        end
    end

    assign bus.x           = vis ? hCnt : 10'd0;
    assign bus.y           = vis ? vCnt[8:0] : 9'd0;
    assign bus.hsync       = hsyncQ;
    assign bus.vsync       = vsyncQ;
    assign bus.video_on    = videoOnQ;
    assign bus.rgb         = rgbQ;
    assign bus.frame_start = frameStartQ;
endmodule
